// File: rtl/grasspopper_out_serializer.sv
// -----------------------------------------------------------------------------
// grasspopper_out_serializer
//
// Purpose:
//   Captures 128-bit ciphertext blocks from the grasspopper encoder pipeline
//   (which has no backpressure), buffers them in a small block FIFO and emits
//   each block as 16 bytes, MSB byte first, on a valid/ready byte stream.
//   A block that arrives while the FIFO is full and nothing is leaving it is
//   dropped, and a sticky overflow flag is raised.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   block_i        128-bit ciphertext block (encoder data_o)
//   block_valid_i  block strobe (encoder valid_o)
//   byte_o         current output byte (0 when no byte is offered)
//   byte_valid_o   byte_o holds a valid byte
//   byte_ready_i   sink accepts byte_o this cycle
//   fill_o         blocks held in the FIFO (block in the shift register excluded)
//   overflow_o     sticky: a block was dropped because the FIFO was full
//   idle_o         FIFO empty and serializer idle
//   byte_last_o    (only with GP_SERIALIZER_LAST_EN) marks the 16th byte of a block
//
// Configuration:
//   GP_SERIALIZER_LAST_EN  when defined, adds the byte_last_o output.
// -----------------------------------------------------------------------------
module grasspopper_out_serializer #(
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      block_i,
    input  logic              block_valid_i,
    output logic [7:0]        byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic [ADDR_W:0]   fill_o,
    output logic              overflow_o,
    output logic              idle_o
`ifdef GP_SERIALIZER_LAST_EN
    ,
    output logic              byte_last_o
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [127:0]      mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [127:0]      shreg;
    logic [3:0]        cnt;
    logic              ovf;

    logic              empty;
    logic              full;
    logic              accept;
    logic              pop;
    logic              shift;
    logic              push;

    // Pointers carry one extra MSB so that equal addresses can be told apart
    // as empty (MSBs equal) or full (MSBs differ).
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign accept = byte_valid_o && byte_ready_i;

    // ---------------- next-state / control ----------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (cnt != 4'd15) begin
                        shift = 1'b1;
                    end else if (!empty) begin
                        // Chain straight into the next block: no idle bubble.
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a block when the head leaves in the same cycle;
    // the write slot is then the one being vacated.
    assign push = block_valid_i && (!full || pop);

    // ---------------- state, pointers, counter, shift register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= 4'd0;
            shreg   <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (block_valid_i && !push) begin
                ovf <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shreg  <= mem[rd_ptr[ADDR_W-1:0]];
                cnt    <= 4'd0;
            end else if (shift) begin
                shreg  <= {shreg[119:0], 8'h00};
                cnt    <= cnt + 4'd1;
            end
        end
    end

    // ---------------- block storage (data only, no reset) ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= block_i;
        end
    end

    // ---------------- outputs ----------------
    assign byte_valid_o = (state_q == SHIFT);
    assign byte_o       = byte_valid_o ? shreg[127:120] : 8'h00;
    assign fill_o       = wr_ptr - rd_ptr;
    assign overflow_o   = ovf;
    assign idle_o       = empty && (state_q == IDLE);

`ifdef GP_SERIALIZER_LAST_EN
    assign byte_last_o  = (state_q == SHIFT) && (cnt == 4'd15);
`endif

endmodule
